// File: rtl/fall_event_scheduler_if.sv
// rtl/fall_event_scheduler_if.sv - event handshake interface for fall_event_scheduler
// Purpose: carries one event index from the scheduler to its consumer.
// Signals:
//   evt_valid  scheduler -> consumer  event presented on evt_idx
//   evt_ready  consumer  -> scheduler event accepted when high with evt_valid
//   evt_idx    scheduler -> consumer  index of the presented event
// Modports: master (scheduler side), slave (consumer side).
interface fall_event_scheduler_if #(
    parameter int IDX_W = 5
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;

    modport master (
        output evt_valid,
        output evt_idx,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        output evt_ready
    );
endinterface

// File: rtl/fall_event_scheduler.sv
// rtl/fall_event_scheduler.sv - per-bit falling-edge capture with round-robin event hand-off
// Purpose: latches 1->0 transitions of each monitored bit into a sticky pending vector and
//   presents eligible (pending & mask) events one at a time to a single consumer.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   in        monitored signals, synchronous to clk
//   mask      1 = bit eligible for grant, 0 = captured but held back
//   evt       event handshake (master modport): evt_valid, evt_ready, evt_idx
//   pending   sticky captured-fall vector
//   drop_cnt  falls merged into an already-pending bit (saturating)
// Configuration: define FALL_SCHED_DROP_CNT_EN to build the drop counter; otherwise
//   drop_cnt is tied to zero.
module fall_event_scheduler #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in,
    input  logic [WIDTH-1:0]          mask,
    fall_event_scheduler_if.master    evt,
    output logic [WIDTH-1:0]          pending,
    output logic [15:0]               drop_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] in_q, in_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             evt_valid_q, evt_valid_d;
    logic [IDX_W-1:0] evt_idx_q, evt_idx_d;

    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] elig;
    logic [WIDTH-1:0] clr;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    int               j;

    // Round-robin search: first eligible bit at or above rr_ptr, wrapping past WIDTH-1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        j          = 0;
        for (int k = 0; k < WIDTH; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end
            cand = IDX_W'(j);
            if (!pick_found && elig[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        fall        = in_q & ~in;
        elig        = pending_q & mask;
        in_d        = in;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        evt_valid_d = evt_valid_q;
        evt_idx_d   = evt_idx_q;
        clr         = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    evt_idx_d   = pick_idx;
                    evt_valid_d = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Mask is ignored here: a granted bit is always delivered and cleared.
                if (evt_valid_q && evt.evt_ready) begin
                    clr         = WIDTH'(1) << evt_idx_q;
                    rr_ptr_d    = (evt_idx_q == IDX_W'(WIDTH - 1)) ? '0
                                                                  : evt_idx_q + IDX_W'(1);
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                evt_valid_d = 1'b0;
            end
        endcase

        // A fall arriving on the same edge as its clear re-sets the bit so no event is lost.
        pending_d = (pending_q & ~clr) | fall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_q        <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_q        <= in_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
        end
    end

`ifdef FALL_SCHED_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // One count per edge when any fall lands on a bit that was already pending.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (|(fall & pending_q) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_idx   = evt_idx_q;
    assign pending       = pending_q;

endmodule
